// File: rtl/bram_copy_engine_pkg.sv
// Shared definitions for the camera frame-buffer BRAM copy path.
package pcam_bram_pkg;

  localparam int FRAME_W    = 320;
  localparam int FRAME_H    = 240;
  localparam int DEF_DEPTH  = FRAME_W * FRAME_H;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 12;

  // Legacy-compatible FSM encoding shared by the copy engine.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/bram_copy_engine_if.sv
// Source-read / destination-write BRAM port bundle of the copy engine.
interface bram_copy_engine_if
  import pcam_bram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_rdata;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_wdata;

  modport master (
    output src_en, src_addr, dst_we, dst_addr, dst_wdata,
    input  src_rdata
  );

  modport slave (
    input  src_en, src_addr, dst_we, dst_addr, dst_wdata,
    output src_rdata
  );

endinterface

// File: rtl/bram_copy_engine_rd_lat_pipe.sv
// Valid + address delay line matching the source BRAM read latency.
module rd_lat_pipe
  import pcam_bram_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  // Shift each issued read along so it emerges when its data is on src_rdata.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/bram_copy_engine.sv
// Copies one frame from a source BRAM to a destination BRAM, word by word,
// pausing whenever copy_enable is low and draining in-flight reads at frame end.
module bram_copy_engine
  import pcam_bram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                copy_enable,
  bram_copy_engine_if.master  bus,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic              last_write;

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (bus.src_en),
    .in_addr   (bus.src_addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  // The final word's data is on src_rdata now; it is written next cycle.
  assign last_write = (state == ST_DRAIN) && pipe_valid && (pipe_addr == LAST_ADDR);

  // Read-side FSM: issues ascending reads, pauses on copy_enable low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      bus.src_en   <= 1'b0;
      bus.src_addr <= '0;
      busy         <= 1'b0;
    end else begin
      bus.src_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          ptr <= '0;
          if (copy_enable) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy <= 1'b1;
          if (copy_enable) begin
            bus.src_en   <= 1'b1;
            bus.src_addr <= ptr;
            if (ptr == LAST_ADDR) state <= ST_DRAIN;
            else                  ptr   <= ptr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_write) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Write side: land each completed read and flag the frame's last word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.dst_we    <= 1'b0;
      bus.dst_addr  <= '0;
      bus.dst_wdata <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      bus.dst_we <= pipe_valid;
      if (pipe_valid) begin
        bus.dst_addr  <= pipe_addr;
        bus.dst_wdata <= bus.src_rdata;
      end
      frame_done <= last_write;
      if (last_write) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
